// File: rtl/bran_pkg.sv
// Shared types and helpers for the branch predict/resolve unit.
package bran_pkg;

   typedef enum logic [2:0] {
      BEQ  = 3'b000,
      BNE  = 3'b001,
      BLT  = 3'b100,
      BGE  = 3'b101,
      BLTU = 3'b110,
      BGEU = 3'b111
   } br_funct3_e;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } bran_fsm_e;

   // Weakly-not-taken: MSB clear, all lower bits set.
   function automatic int unsigned ctr_rst(int unsigned bits);
      return (32'd1 << (bits - 1)) - 32'd1;
   endfunction

   // funct3 010/011 are not branch encodings.
   function automatic logic br_legal(logic [2:0] ctrl);
      return ctrl[2:1] != 2'b01;
   endfunction

   function automatic logic br_taken(
      logic [2:0] ctrl,
      logic       neg,
      logic       zero,
      logic       carry
   );
      logic t;
      t = 1'b0;
      case (br_funct3_e'(ctrl))
         BEQ:     t = zero;
         BNE:     t = !zero;
         BLT:     t = neg;
         BGE:     t = !neg;
         BLTU:    t = carry;
         BGEU:    t = !carry;
         default: t = 1'b0;
      endcase
      return t;
   endfunction

endpackage

// File: rtl/bran_sat_ctr.sv
// Saturating up/down step for one BHT counter (combinational).
module bran_sat_ctr #(
   parameter int CTR_BITS = 2
) (
   input  logic [CTR_BITS-1:0] cnt,
   input  logic                up,
   output logic [CTR_BITS-1:0] nxt
);

   localparam logic [CTR_BITS-1:0] MAX = '1;

   always_comb begin
      nxt = cnt;
      if (up) begin
         if (cnt != MAX) nxt = cnt + 1'b1;
      end else begin
         if (cnt != '0) nxt = cnt - 1'b1;
      end
   end

endmodule

// File: rtl/bran_pred_unit.sv
// BHT-based branch predict/resolve unit with sweep-clear FSM.
// Define BRAN_PRED_STATS_EN to add branch/mispredict counters.
module bran_pred_unit
   import bran_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int BHT_DEPTH = 64,
   parameter int CTR_BITS  = 2,
   parameter int IDX_LSB   = 2
) (
   input  logic            clk,
   input  logic            nReset,
   input  logic [XLEN-1:0] lk_pc,
   output logic            lk_taken,
   input  logic            rs_valid,
   input  logic            rs_branch,
   input  logic [2:0]      rs_ctrl,
   input  logic            rs_neg,
   input  logic            rs_zero,
   input  logic            rs_carry,
   input  logic [XLEN-1:0] rs_pc,
   input  logic [XLEN-1:0] rs_target,
   input  logic            rs_pred_taken,
   output logic            redir_valid,
   output logic [XLEN-1:0] redir_pc,
`ifdef BRAN_PRED_STATS_EN
   output logic [31:0]     stat_branches,
   output logic [31:0]     stat_mispred,
`endif
   input  logic            bht_clear,
   output logic            busy
);

   localparam int IDX_W = $clog2(BHT_DEPTH);
   localparam logic [CTR_BITS-1:0] CTR_RST =
      CTR_BITS'(ctr_rst(CTR_BITS));
   localparam logic [IDX_W-1:0] LAST = IDX_W'(BHT_DEPTH - 1);

   logic [CTR_BITS-1:0] bht [BHT_DEPTH];
   logic [CTR_BITS-1:0] ctr_nxt;
   logic [IDX_W-1:0]    lk_idx, rs_idx;
   logic [IDX_W-1:0]    ptr, ptr_nxt;
   bran_fsm_e           state, state_nxt;
   logic                fire, taken, mispred;

   assign lk_idx  = lk_pc[IDX_LSB +: IDX_W];
   assign rs_idx  = rs_pc[IDX_LSB +: IDX_W];
   assign busy    = (state == CLEAR);
   assign taken   = br_taken(rs_ctrl, rs_neg, rs_zero, rs_carry);
   assign fire    = rs_valid & rs_branch & br_legal(rs_ctrl)
                  & (state == IDLE);
   assign mispred = fire & (taken != rs_pred_taken);

   // No bypass: lookup sees the counter before this cycle's update.
   assign lk_taken = (state == IDLE) & bht[lk_idx][CTR_BITS-1];

   bran_sat_ctr #(.CTR_BITS(CTR_BITS)) u_ctr (
      .cnt (bht[rs_idx]),
      .up  (taken),
      .nxt (ctr_nxt)
   );

   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      unique case (state)
         IDLE: begin
            if (bht_clear) begin
               state_nxt = CLEAR;
               ptr_nxt   = '0;
            end
         end
         CLEAR: begin
            ptr_nxt = ptr + 1'b1;
            if (ptr == LAST) begin
               state_nxt = IDLE;
               ptr_nxt   = '0;
            end
         end
         default: begin
            state_nxt = IDLE;
            ptr_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         state <= IDLE;
         ptr   <= '0;
      end else begin
         state <= state_nxt;
         ptr   <= ptr_nxt;
      end
   end

   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= CTR_RST;
      end else if (state == CLEAR) begin
         bht[ptr] <= CTR_RST;
      end else if (fire) begin
         bht[rs_idx] <= ctr_nxt;
      end
   end

   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         redir_valid <= 1'b0;
         redir_pc    <= '0;
      end else begin
         redir_valid <= mispred;
         if (fire)
            redir_pc <= taken ? rs_target : rs_pc + XLEN'(4);
      end
   end

`ifdef BRAN_PRED_STATS_EN
   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         stat_branches <= '0;
         stat_mispred  <= '0;
      end else begin
         if (fire && stat_branches != '1)
            stat_branches <= stat_branches + 32'd1;
         if (mispred && stat_mispred != '1)
            stat_mispred <= stat_mispred + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_bran_pred_unit.sv
// Self-checking bench for bran_pred_unit: vector table plus
// hand-written clear-sweep and reset-during-sweep sequences.
module tb_bran_pred_unit;
   import bran_pkg::*;

   typedef struct {
      logic [2:0]  ctrl;
      logic        neg;
      logic        zero;
      logic        carry;
      logic [31:0] pc;
      logic [31:0] tgt;
      logic        pred;
      logic        valid;
      logic        branch;
      logic        rv;
      logic [31:0] epc;
      logic        lk;
   } vec_t;

   typedef struct {
      logic        rv;
      logic [31:0] pc;
      logic        lk;
   } exp_t;

   logic        clk = 1'b0;
   logic        nReset;
   logic [31:0] lk_pc;
   logic        lk_taken;
   logic        rs_valid, rs_branch;
   logic [2:0]  rs_ctrl;
   logic        rs_neg, rs_zero, rs_carry;
   logic [31:0] rs_pc, rs_target;
   logic        rs_pred_taken;
   logic        redir_valid;
   logic [31:0] redir_pc;
   logic        bht_clear;
   logic        busy;
`ifdef BRAN_PRED_STATS_EN
   logic [31:0] stat_branches, stat_mispred;
   int          st_br = 0;
   int          st_mp = 0;
`endif

   int   n_vec = 0;
   int   n_err = 0;
   exp_t sb[$];
   vec_t vt[$];

   always #5 clk = ~clk;

   bran_pred_unit dut (
      .clk           (clk),
      .nReset        (nReset),
      .lk_pc         (lk_pc),
      .lk_taken      (lk_taken),
      .rs_valid      (rs_valid),
      .rs_branch     (rs_branch),
      .rs_ctrl       (rs_ctrl),
      .rs_neg        (rs_neg),
      .rs_zero       (rs_zero),
      .rs_carry      (rs_carry),
      .rs_pc         (rs_pc),
      .rs_target     (rs_target),
      .rs_pred_taken (rs_pred_taken),
      .redir_valid   (redir_valid),
      .redir_pc      (redir_pc),
`ifdef BRAN_PRED_STATS_EN
      .stat_branches (stat_branches),
      .stat_mispred  (stat_mispred),
`endif
      .bht_clear     (bht_clear),
      .busy          (busy)
   );

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // nzc = {neg,zero,carry}; vb = {valid,branch}
   function automatic vec_t mk(
      logic [2:0] c, logic [2:0] nzc, logic [31:0] pc,
      logic [31:0] tgt, logic pred, logic [1:0] vb,
      logic rv, logic [31:0] epc, logic lk);
      vec_t v;
      v.ctrl = c;
      {v.neg, v.zero, v.carry} = nzc;
      v.pc = pc; v.tgt = tgt; v.pred = pred;
      {v.valid, v.branch} = vb;
      v.rv = rv; v.epc = epc; v.lk = lk;
      return v;
   endfunction

   // Called at a negedge; checks at the following negedge.
   task automatic apply(string tag, vec_t v);
      exp_t e;
      rs_valid = v.valid; rs_branch = v.branch;
      rs_ctrl = v.ctrl; rs_neg = v.neg;
      rs_zero = v.zero; rs_carry = v.carry;
      rs_pc = v.pc; rs_target = v.tgt;
      rs_pred_taken = v.pred; lk_pc = v.pc;
      e.rv = v.rv; e.pc = v.epc; e.lk = v.lk;
      sb.push_back(e);
`ifdef BRAN_PRED_STATS_EN
      if (v.valid && v.branch && v.ctrl[2:1] != 2'b01) begin
         st_br++;
         if (v.rv) st_mp++;
      end
`endif
      @(negedge clk);
      rs_valid = 1'b0; rs_branch = 1'b0;
      e = sb.pop_front();
      chk({tag, " redir_valid"}, {31'b0, redir_valid}, {31'b0, e.rv});
      if (e.rv) chk({tag, " redir_pc"}, redir_pc, e.pc);
      chk({tag, " lk_taken"}, {31'b0, lk_taken}, {31'b0, e.lk});
   endtask

   task automatic sweep(string tag, output int cnt);
      cnt = 0;
      @(negedge clk);
      bht_clear = 1'b1;
      @(negedge clk);
      bht_clear = 1'b0;
      for (int k = 0; k < 200 && busy; k++) begin
         cnt++;
         @(negedge clk);
      end
      chk({tag, " busy_cycles"}, cnt, 64);
   endtask

   initial begin
      int bc;
      nReset = 1'b0; lk_pc = 32'h100;
      rs_valid = 0; rs_branch = 0; rs_ctrl = 0;
      rs_neg = 0; rs_zero = 0; rs_carry = 0;
      rs_pc = 0; rs_target = 0; rs_pred_taken = 0;
      bht_clear = 0;

      vt.push_back(mk(3'b000, 3'b010, 32'h100, 32'h80, 0, 2'b11, 1, 32'h80, 1));
      vt.push_back(mk(3'b000, 3'b010, 32'h100, 32'h80, 1, 2'b11, 0, 0, 1));
      vt.push_back(mk(3'b000, 3'b010, 32'h100, 32'h80, 1, 2'b11, 0, 0, 1));
      vt.push_back(mk(3'b000, 3'b000, 32'h100, 32'h80, 1, 2'b11, 1, 32'h104, 1));
      vt.push_back(mk(3'b000, 3'b000, 32'h100, 32'h80, 0, 2'b11, 0, 0, 0));
      vt.push_back(mk(3'b000, 3'b000, 32'h100, 32'h80, 0, 2'b11, 0, 0, 0));
      vt.push_back(mk(3'b000, 3'b000, 32'h100, 32'h80, 1, 2'b11, 1, 32'h104, 0));
      vt.push_back(mk(3'b000, 3'b010, 32'h100, 32'h80, 0, 2'b11, 1, 32'h80, 0));
      vt.push_back(mk(3'b000, 3'b010, 32'h100, 32'h80, 0, 2'b11, 1, 32'h80, 1));
      vt.push_back(mk(3'b101, 3'b100, 32'hFFFFFFFC, 32'h40, 1, 2'b11, 1, 32'h0, 0));
      vt.push_back(mk(3'b110, 3'b001, 32'h204, 32'h300, 1, 2'b11, 0, 0, 1));
      vt.push_back(mk(3'b001, 3'b000, 32'h208, 32'h1000, 0, 2'b11, 1, 32'h1000, 1));
      vt.push_back(mk(3'b100, 3'b100, 32'h20C, 32'h2000, 0, 2'b11, 1, 32'h2000, 1));
      vt.push_back(mk(3'b111, 3'b000, 32'h210, 32'h3000, 1, 2'b11, 0, 0, 1));
      vt.push_back(mk(3'b111, 3'b001, 32'h214, 32'h3000, 0, 2'b11, 0, 0, 0));
      vt.push_back(mk(3'b100, 3'b000, 32'h218, 32'h4000, 1, 2'b11, 1, 32'h21C, 0));
      vt.push_back(mk(3'b001, 3'b010, 32'h21C, 32'h5000, 1, 2'b11, 1, 32'h220, 0));
      vt.push_back(mk(3'b010, 3'b000, 32'h204, 32'h6000, 1, 2'b11, 0, 0, 1));
      vt.push_back(mk(3'b011, 3'b000, 32'h204, 32'h6000, 1, 2'b11, 0, 0, 1));
      vt.push_back(mk(3'b000, 3'b000, 32'h204, 32'h6000, 1, 2'b10, 0, 0, 1));
      vt.push_back(mk(3'b000, 3'b000, 32'h204, 32'h6000, 1, 2'b01, 0, 0, 1));

      #1;
      chk("rst busy", {31'b0, busy}, 0);
      chk("rst redir_valid", {31'b0, redir_valid}, 0);
      chk("rst redir_pc", redir_pc, 0);
      repeat (3) @(negedge clk);
      nReset = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 64; i++) begin
         lk_pc = i * 4;
         #1 chk($sformatf("rst lk[%0d]", i), {31'b0, lk_taken}, 0);
      end
      @(negedge clk);

      for (int i = 0; i < vt.size(); i++) begin
         if (i == 1) begin
            // lookup in the update cycle still sees the old counter
            lk_pc = 32'h100; rs_pc = 32'h100;
            rs_valid = 1; rs_branch = 1; rs_ctrl = 3'b000;
            rs_zero = 1; #1;
            chk("no_bypass lk", {31'b0, lk_taken}, 1);
            rs_valid = 0;
         end
         apply($sformatf("v%0d", i), vt[i]);
      end
      chk("pulse end", {31'b0, redir_valid}, 0);

`ifdef BRAN_PRED_STATS_EN
      chk("stat_branches", stat_branches, st_br);
      chk("stat_mispred", stat_mispred, st_mp);
`endif

      // Clear sweep with lookup, resolve and re-clear during busy
      lk_pc = 32'h208;
      bht_clear = 1'b1;
      @(negedge clk);
      bht_clear = 1'b0;
      bc = 0;
      for (int k = 0; k < 200 && busy; k++) begin
         bc++;
         if (k == 5) chk("clr lk", {31'b0, lk_taken}, 0);
         if (k == 8) begin
            rs_valid = 1; rs_branch = 1; rs_ctrl = 3'b000;
            rs_zero = 1; rs_pc = 32'h20C; rs_target = 32'h9000;
            rs_pred_taken = 0; bht_clear = 1'b1;
         end
         if (k == 9) begin
            chk("clr redir", {31'b0, redir_valid}, 0);
            rs_valid = 0; rs_branch = 0; bht_clear = 1'b0;
         end
         @(negedge clk);
      end
      chk("clr busy_cycles", bc, 64);
      lk_pc = 32'h208; #1;
      chk("clr lk 208", {31'b0, lk_taken}, 0);
      lk_pc = 32'h20C; #1;
      chk("clr lk 20C", {31'b0, lk_taken}, 0);
`ifdef BRAN_PRED_STATS_EN
      chk("clr stat_branches", stat_branches, st_br);
      chk("clr stat_mispred", stat_mispred, st_mp);
`endif
      @(negedge clk);
      apply("post_clr", mk(3'b000, 3'b010, 32'h208, 32'h700, 0, 2'b11, 1, 32'h700, 1));

      // Reset in the middle of a sweep
      apply("tr40a", mk(3'b000, 3'b010, 32'hA0, 32'h800, 0, 2'b11, 1, 32'h800, 1));
      apply("tr40b", mk(3'b000, 3'b010, 32'hA0, 32'h800, 1, 2'b11, 0, 0, 1));
      bht_clear = 1'b1;
      @(negedge clk);
      bht_clear = 1'b0;
      repeat (19) @(negedge clk);
      chk("mid busy", {31'b0, busy}, 1);
      #2 nReset = 1'b0;
      #1;
      chk("arst busy", {31'b0, busy}, 0);
      chk("arst redir_pc", redir_pc, 0);
`ifdef BRAN_PRED_STATS_EN
      chk("arst stat_branches", stat_branches, 0);
      chk("arst stat_mispred", stat_mispred, 0);
      st_br = 0; st_mp = 0;
`endif
      @(negedge clk);
      nReset = 1'b1;
      @(negedge clk);
      chk("post_rst busy", {31'b0, busy}, 0);
      lk_pc = 32'hA0; #1;
      chk("post_rst lk A0", {31'b0, lk_taken}, 0);
      @(negedge clk);
      apply("post_rst", mk(3'b000, 3'b010, 32'hA0, 32'h800, 0, 2'b11, 1, 32'h800, 1));
      sweep("resweep", bc);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
